// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with branch/jump resolution.
// Taken control transfers redirect fetch for one cycle, then squash two younger slots.
module ex_mem_stage #(
   parameter int DATA_WIDTH = 32,
   parameter int PC_W       = 9
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  stall,
   input  logic                  flush,
   input  logic                  valid_i,
   input  logic [DATA_WIDTH-1:0] ALUResult,
   input  logic [DATA_WIDTH-1:0] jalr_src,
   input  logic [DATA_WIDTH-1:0] store_data,
   input  logic [DATA_WIDTH-1:0] Imm,
   input  logic [PC_W-1:0]       Curr_Pc,
   input  logic [4:0]            rd_i,
   input  logic                  RegWrite_i,
   input  logic                  MemRead_i,
   input  logic                  MemWrite_i,
   input  logic                  MemtoReg_i,
   input  logic                  Branch_i,
   input  logic                  jal,
   input  logic                  jalr,
   output logic                  valid_o,
   output logic [DATA_WIDTH-1:0] alu_result_o,
   output logic [DATA_WIDTH-1:0] store_data_o,
   output logic [4:0]            rd_o,
   output logic                  RegWrite_o,
   output logic                  MemRead_o,
   output logic                  MemWrite_o,
   output logic                  MemtoReg_o,
   output logic                  redirect,
   output logic [PC_W-1:0]       redirect_pc,
   output logic                  kill,
   output logic [15:0]           retired
);

   typedef enum logic [1:0] {IDLE, REDIR, KILL} state_t;

   state_t          state, state_next;
   logic            taken;
   logic            live;
   logic            start_redir;
   logic [PC_W-1:0] target;
   logic            unused_bits;

   always_comb begin
      taken       = valid_i & (jal | jalr | (Branch_i & ALUResult[0]));
      target      = jalr ? {jalr_src[PC_W-1:1], 1'b0} : Curr_Pc + Imm[PC_W-1:0];
      live        = valid_i & ~flush & (state == IDLE);
      unused_bits = ^{jalr_src[DATA_WIDTH-1:PC_W], jalr_src[0], Imm[DATA_WIDTH-1:PC_W]};
   end

   always_comb begin
      state_next  = state;
      redirect    = 1'b0;
      kill        = 1'b0;
      start_redir = 1'b0;
      unique case (state)
         IDLE: begin
            // taken already implies valid_i; a flushed jump is simply dropped
            if (taken && !flush) begin
               state_next  = REDIR;
               start_redir = 1'b1;
            end
         end
         REDIR: begin
            state_next = KILL;
            redirect   = 1'b1;
            kill       = 1'b1;
         end
         KILL: begin
            state_next = IDLE;
            kill       = 1'b1;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         valid_o      <= 1'b0;
         alu_result_o <= '0;
         store_data_o <= '0;
         rd_o         <= '0;
         RegWrite_o   <= 1'b0;
         MemRead_o    <= 1'b0;
         MemWrite_o   <= 1'b0;
         MemtoReg_o   <= 1'b0;
         redirect_pc  <= '0;
         retired      <= '0;
      end else if (!stall) begin
         state        <= state_next;
         valid_o      <= live;
         alu_result_o <= ALUResult;
         store_data_o <= store_data;
         rd_o         <= rd_i;
         RegWrite_o   <= RegWrite_i & live;
         MemRead_o    <= MemRead_i & live;
         MemWrite_o   <= MemWrite_i & live;
         MemtoReg_o   <= MemtoReg_i;
         if (start_redir)
            redirect_pc <= target;
         if (valid_o)
            retired <= retired + 16'd1;
      end
   end

endmodule
